bcd_to_bin_seq: RTL and testbench

Sequential, parametrised multi-digit BCD-to-binary converter. Takes one packed word of DIGITS BCD digits through a valid/ready handshake and processes one digit per clock, MSD first, using acc = acc*10 + digit. The result is presented on a held valid/ready output. It flags invalid digits (>9) and results that do not fit in OUT_W bits. It is the width-generic, streaming successor to the fixed-width combinational BCD decoder and sits between the BCD capture path and the binary datapath.

---
 rtl/bcd_to_bin_seq_if.sv | 37 +++
 rtl/bcd_to_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// Input side carries a packed BCD word; output side a held binary result.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 27
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_bin;
    logic                  out_err;
    logic                  out_ovf;

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_err,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_err,
        output out_ovf
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Optional BCD2BIN_SAT_EN: saturate out_bin to all ones on overflow.
module bcd_to_bin_seq #(
    parameter int DIGITS = 8,
    parameter int OUT_W  = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_to_bin_seq_if.slave bus,
    output logic            busy
);
    localparam int IN_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NXT_W = OUT_W + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IN_W-1:0]    r_sreg;
    logic [OUT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_ovf;
    logic [OUT_W-1:0]   r_out_bin;
    logic               r_out_err;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [3:0]         w_dig;
    logic               w_dig_ok;
    logic [3:0]         w_d;
    logic [NXT_W-1:0]   w_next;
    logic               w_ovf_step;
    logic               w_err_all;
    logic               w_ovf_all;
    logic [OUT_W-1:0]   w_res;

    // Digit datapath: top nibble of the shift register is the current digit
    assign w_dig      = r_sreg[IN_W-1 -: 4];
    assign w_dig_ok   = (w_dig <= 4'd9);
    assign w_d        = w_dig_ok ? w_dig : 4'd0;
    assign w_next     = ({4'b0000, r_acc} * NXT_W'(10))
                      + {{(NXT_W-4){1'b0}}, w_d};
    assign w_ovf_step = |w_next[NXT_W-1:OUT_W];
    assign w_err_all  = r_err | ~w_dig_ok;
    assign w_ovf_all  = r_ovf | w_ovf_step;
    assign w_last     = (r_cnt == CNT_W'(DIGITS - 1));

`ifdef BCD2BIN_SAT_EN
    assign w_res = w_ovf_all ? {OUT_W{1'b1}} : w_next[OUT_W-1:0];
`else
    assign w_res = w_next[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_out_bin <= '0;
            r_out_err <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if (w_accept) begin
            r_sreg <= bus.in_bcd;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_step) begin
            r_sreg <= r_sreg << 4;
            r_acc  <= w_next[OUT_W-1:0];
            r_cnt  <= r_cnt + 1'b1;
            r_err  <= w_err_all;
            r_ovf  <= w_ovf_all;
            // Result registers only move on entry to DONE
            if (w_last) begin
                r_out_bin <= w_res;
                r_out_err <= w_err_all;
                r_out_ovf <= w_ovf_all;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_bin   = r_out_bin;
    assign bus.out_err   = r_out_err;
    assign bus.out_ovf   = r_out_ovf;
    assign busy          = (r_state == S_CONV);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed and randomized bench for bcd_to_bin_seq across three sizes.
// Expected results come from a positional-sum model of the BCD word.
module tb_bcd_to_bin_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_busy, b_busy, c_busy;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.DIGITS(4), .OUT_W(14)) a ();
    bcd_to_bin_seq_if #(.DIGITS(4), .OUT_W(10)) b ();
    bcd_to_bin_seq_if #(.DIGITS(1), .OUT_W(4))  c ();

    bcd_to_bin_seq #(.DIGITS(4), .OUT_W(14)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a.slave), .busy(a_busy));
    bcd_to_bin_seq #(.DIGITS(4), .OUT_W(10)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b.slave), .busy(b_busy));
    bcd_to_bin_seq #(.DIGITS(1), .OUT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(c.slave), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] w, input int ow,
                                  output logic [31:0] bin,
                                  output logic err, output logic ovf);
        longint v = 0;
        longint p = 1;
        longint lim = longint'(1) << ow;
        err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int d = int'(w[4*k +: 4]);
            if (d > 9) err = 1'b1;
            else v += longint'(d) * p;
            p *= 10;
        end
        ovf = (v >= lim);
`ifdef BCD2BIN_SAT_EN
        bin = ovf ? 32'(lim - 1) : 32'(v);
`else
        bin = 32'(v % lim);
`endif
    endfunction

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 4) == 0)
                w[4*k +: 4] = 4'($urandom_range(10, 15));
            else
                w[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    function automatic logic [31:0] f_rdy(input int id);
        return (id == 0) ? 32'(a.in_ready) : 32'(b.in_ready);
    endfunction
    function automatic logic [31:0] f_vld(input int id);
        return (id == 0) ? 32'(a.out_valid) : 32'(b.out_valid);
    endfunction
    function automatic logic [31:0] f_busy(input int id);
        return (id == 0) ? 32'(a_busy) : 32'(b_busy);
    endfunction
    function automatic logic [31:0] f_bin(input int id);
        return (id == 0) ? 32'(a.out_bin) : 32'(b.out_bin);
    endfunction
    function automatic logic [31:0] f_err(input int id);
        return (id == 0) ? 32'(a.out_err) : 32'(b.out_err);
    endfunction
    function automatic logic [31:0] f_ovf(input int id);
        return (id == 0) ? 32'(a.out_ovf) : 32'(b.out_ovf);
    endfunction

    task automatic drive_in(input int id, input logic v,
                            input logic [15:0] w);
        if (id == 0) begin a.in_valid = v; a.in_bcd = w; end
        else begin b.in_valid = v; b.in_bcd = w; end
    endtask

    task automatic set_rdy(input int id, input logic r);
        if (id == 0) a.out_ready = r;
        else b.out_ready = r;
    endtask

    // Accept w, optionally keep in_valid high with word kw, check result
    task automatic convert(input int id, input logic [15:0] w,
                           input bit keep, input logic [15:0] kw);
        int n;
        logic [31:0] eb;
        logic ee, eo;
        n = 0;
        while (f_rdy(id) !== 32'd1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_accept", f_rdy(id), 32'd1);
        drive_in(id, 1'b1, w);
        @(posedge clk); #1;
        chk("busy_after_accept", f_busy(id), 32'd1);
        if (keep) drive_in(id, 1'b1, kw);
        else drive_in(id, 1'b0, w);
        n = 0;
        while (f_vld(id) !== 32'd1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'd4);
        model(w, (id == 0) ? 14 : 10, eb, ee, eo);
        chk("out_bin", f_bin(id), eb);
        chk("out_err", f_err(id), 32'(ee));
        chk("out_ovf", f_ovf(id), 32'(eo));
    endtask

    task automatic consume(input int id);
        set_rdy(id, 1'b1);
        @(posedge clk); #1;
        chk("out_valid_drop", f_vld(id), 32'd0);
        chk("in_ready_rise", f_rdy(id), 32'd1);
        set_rdy(id, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        a.in_valid = 0; a.in_bcd = '0; a.out_ready = 0;
        b.in_valid = 0; b.in_bcd = '0; b.out_ready = 0;
        c.in_valid = 0; c.in_bcd = '0; c.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a.in_ready), 32'd1);
        chk("rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_out_bin", 32'(a.out_bin), 32'd0);
        chk("rst_out_err", 32'(a.out_err), 32'd0);
        chk("rst_out_ovf", 32'(a.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        convert(0, 16'h9999, 1'b0, 16'h0); consume(0);
        convert(0, 16'h12A4, 1'b0, 16'h0); consume(0);
        convert(1, 16'h1024, 1'b0, 16'h0); consume(1);
        convert(1, 16'h0999, 1'b0, 16'h0); consume(1);

        // Backpressure with in_valid held high across the conversion
        convert(0, 16'h9999, 1'b1, 16'h0042);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(a.out_valid), 32'd1);
            chk("bp_out_bin", 32'(a.out_bin), 32'd9999);
            chk("bp_in_ready", 32'(a.in_ready), 32'd0);
        end
        a.out_ready = 1'b1;
        @(posedge clk); #1;
        a.out_ready = 1'b0;
        chk("bp_valid_drop", 32'(a.out_valid), 32'd0);
        chk("bp_in_ready_rise", 32'(a.in_ready), 32'd1);
        chk("bp_no_same_edge_accept", 32'(a_busy), 32'd0);
        @(posedge clk); #1;
        chk("bp_second_accept", 32'(a_busy), 32'd1);
        a.in_valid = 1'b0;
        n = 0;
        while (a.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_second_latency", 32'(n), 32'd4);
        chk("bp_second_bin", 32'(a.out_bin), 32'd42);
        consume(0);

        for (int i = 0; i < 25; i++) begin
            convert(0, rnd_word(), 1'b0, 16'h0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            consume(0);
        end
        for (int i = 0; i < 25; i++) begin
            convert(1, rnd_word(), 1'b0, 16'h0);
            consume(1);
        end

        // Reset two cycles into a conversion
        a.in_valid = 1'b1; a.in_bcd = 16'h5678;
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(a.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_out_bin", 32'(a.out_bin), 32'd0);
        chk("mid_rst_out_err", 32'(a.out_err), 32'd0);
        chk("mid_rst_out_ovf", 32'(a.out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_partial_result", 32'(a.out_valid), 32'd0);
        end
        convert(0, 16'h0007, 1'b0, 16'h0); consume(0);

        // Single-digit instance
        c.in_valid = 1'b1; c.in_bcd = 4'h9;
        @(posedge clk); #1;
        c.in_valid = 1'b0;
        chk("c_busy", 32'(c_busy), 32'd1);
        @(posedge clk); #1;
        chk("c_valid_9", 32'(c.out_valid), 32'd1);
        chk("c_bin_9", 32'(c.out_bin), 32'd9);
        chk("c_err_9", 32'(c.out_err), 32'd0);
        c.out_ready = 1'b1;
        @(posedge clk); #1;
        c.out_ready = 1'b0;
        chk("c_in_ready", 32'(c.in_ready), 32'd1);
        c.in_valid = 1'b1; c.in_bcd = 4'hF;
        @(posedge clk); #1;
        c.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("c_valid_f", 32'(c.out_valid), 32'd1);
        chk("c_bin_f", 32'(c.out_bin), 32'd0);
        chk("c_err_f", 32'(c.out_err), 32'd1);
        chk("c_ovf_f", 32'(c.out_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
